booth_seq_mul: RTL and testbench

- Parametrised, multi-cycle radix-4 Booth multiplier; successor to the fixed 256x64 combinational booth_top.
- Retires one radix-4 digit of the multiplier per clock, so area stays roughly constant as width grows.
- Adds a start/done handshake and a per-operation signed/unsigned mode.
- Sits beside booth_top as the area-optimised option for wide operands.

---
 rtl/booth_seq_mul.sv | 119 +++++++++++
 tb/tb_booth_seq_mul.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock,
// start/done handshake, per-operation signed or unsigned operands.
module booth_seq_mul #(
  parameter int A_W = 256,
  parameter int B_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] p
);

  localparam int ITERS = B_W / 2 + 1;
  localparam int W     = A_W + B_W;
  localparam int CW    = $clog2(ITERS + 1);

  if (A_W < 2 || B_W < 4 || (B_W % 2) != 0) begin : g_bad_params
    $error("booth_seq_mul: need A_W >= 2 and even B_W >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_m;
  logic [B_W+2:0] r_b;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_p;
  logic [W-1:0]   w_a_ext;
  logic [1:0]     w_b_top;
  logic [W-1:0]   w_pp;
  logic           w_last;

  assign w_last  = (r_cnt == CW'(ITERS));
  assign w_a_ext = signed_mode ? {{B_W{a[A_W-1]}}, a}
                               : {{B_W{1'b0}}, a};
  assign w_b_top = signed_mode ? {2{b[B_W-1]}} : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Booth digit from the low three bits of the shifted multiplier
  always_comb begin
    w_pp = '0;
    case (r_b[2:0])
      3'b001, 3'b010: w_pp = r_m;
      3'b011:         w_pp = {r_m[W-2:0], 1'b0};
      3'b100:         w_pp = -{r_m[W-2:0], 1'b0};
      3'b101, 3'b110: w_pp = -r_m;
      default:        w_pp = '0;
    endcase
  end

  // Arithmetic is modulo 2^W; the exact product always fits in W bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= w_a_ext;
            r_b   <= {w_b_top, b, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_p <= r_acc;
          end else begin
            r_acc <= r_acc + w_pp;
            r_m   <= {r_m[W-3:0], 2'b00};
            r_b   <= {2'b00, r_b[B_W+2:2]};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed and random checks of booth_seq_mul at the default
// 256x64 size and a small 8x4 instance.
module tb_booth_seq_mul;

  logic clk;
  logic rst;

  logic        s_start;
  logic        s_sm;
  logic [7:0]  s_a;
  logic [3:0]  s_b;
  logic        s_busy;
  logic        s_done;
  logic [11:0] s_p;

  logic         l_start;
  logic         l_sm;
  logic [255:0] l_a;
  logic [63:0]  l_b;
  logic         l_busy;
  logic         l_done;
  logic [319:0] l_p;

  int errs;
  int checks;

  booth_seq_mul #(.A_W(8), .B_W(4)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .signed_mode(s_sm), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .p(s_p)
  );

  booth_seq_mul u_wide (
    .clk(clk), .rst(rst), .start(l_start),
    .signed_mode(l_sm), .a(l_a), .b(l_b),
    .busy(l_busy), .done(l_done), .p(l_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref8(
    input logic sm, input logic [7:0] a,
    input logic [3:0] b);
    int ea;
    int eb;
    int pr;
    ea = sm ? int'($signed(a)) : int'({1'b0, a});
    eb = sm ? int'($signed(b)) : int'({1'b0, b});
    pr = ea * eb;
    return pr[11:0];
  endfunction

  function automatic logic [319:0] ref_wide(
    input logic sm, input logic [255:0] a,
    input logic [63:0] b);
    logic signed [319:0] ea;
    logic signed [319:0] eb;
    logic signed [319:0] pr;
    ea = sm ? {{64{a[255]}}, a} : {64'd0, a};
    eb = sm ? {{256{b[63]}}, b} : {256'd0, b};
    pr = ea * eb;
    return pr;
  endfunction

  task automatic run8(
    input logic sm, input logic [7:0] a,
    input logic [3:0] b,
    output logic [11:0] p, output int lat);
    @(negedge clk);
    s_sm = sm; s_a = a; s_b = b; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = s_p;
    @(posedge clk); #1;
    checks++;
    if (s_done !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse8: done=%b after done cycle, want 0",
               s_done);
    end
  endtask

  task automatic run_wide(
    input logic sm, input logic [255:0] a,
    input logic [63:0] b,
    output logic [319:0] p, output int lat);
    @(negedge clk);
    l_sm = sm; l_a = a; l_b = b; l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    lat = 0;
    while (!l_done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    p = l_p;
    @(posedge clk); #1;
    checks++;
    if (l_done !== 1'b0) begin
      errs++;
      $display("FAIL done_pulse_wide: done=%b after done cycle, want 0",
               l_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_start = 0; s_sm = 0; s_a = '0; s_b = '0;
    l_start = 0; l_sm = 0; l_a = '0; l_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if ({s_busy, s_done} !== 2'b00) begin
      errs++;
      $display("FAIL reset8_ctl: busy,done=%b want 00", {s_busy, s_done});
    end
    if (s_p !== 12'h000) begin
      errs++;
      $display("FAIL reset8_p: p=%h want 000", s_p);
    end
    if ({l_busy, l_done} !== 2'b00) begin
      errs++;
      $display("FAIL resetw_ctl: busy,done=%b want 00", {l_busy, l_done});
    end
    if (l_p !== 320'd0) begin
      errs++;
      $display("FAIL resetw_p: p=%h want 0", l_p);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_small_vectors();
    logic        sm_t [3];
    logic [7:0]  a_t  [3];
    logic [3:0]  b_t  [3];
    logic [11:0] e_t  [3];
    logic [11:0] p;
    int lat;
    sm_t = '{1'b1, 1'b0, 1'b1};
    a_t  = '{8'h80, 8'hFF, 8'h05};
    b_t  = '{4'h8, 4'hF, 4'hD};
    e_t  = '{12'h400, 12'hEF1, 12'hFF1};
    for (int i = 0; i < 3; i++) begin
      run8(sm_t[i], a_t[i], b_t[i], p, lat);
      checks += 2;
      if (lat !== 4) begin
        errs++;
        $display("FAIL lat8_%0d: latency=%0d want 4", i, lat);
      end
      if (p !== e_t[i]) begin
        errs++;
        $display("FAIL vec8_%0d: p=%h want %h", i, p, e_t[i]);
      end
    end
  endtask

  task automatic test_wide_vectors();
    logic         sm_t [4];
    logic [255:0] a_t  [4];
    logic [63:0]  b_t  [4];
    logic [319:0] e_t  [4];
    logic [319:0] one;
    logic [319:0] p;
    int lat;
    one = 320'd1;
    sm_t[0] = 1'b1;
    a_t[0]  = {1'b0, {255{1'b1}}};
    b_t[0]  = {1'b0, {63{1'b1}}};
    e_t[0]  = (one << 318) - (one << 255) - (one << 63) + one;
    sm_t[1] = 1'b0;
    a_t[1]  = {256{1'b1}};
    b_t[1]  = {64{1'b1}};
    e_t[1]  = 320'd0 - (one << 256) - (one << 64) + one;
    sm_t[2] = 1'b1;
    a_t[2]  = {256{1'b1}};
    b_t[2]  = {64{1'b1}};
    e_t[2]  = one;
    sm_t[3] = 1'b1;
    a_t[3]  = {1'b1, 255'd0};
    b_t[3]  = {1'b1, 63'd0};
    e_t[3]  = one << 318;
    for (int i = 0; i < 4; i++) begin
      run_wide(sm_t[i], a_t[i], b_t[i], p, lat);
      checks += 2;
      if (lat !== 34) begin
        errs++;
        $display("FAIL latw_%0d: latency=%0d want 34", i, lat);
      end
      if (p !== e_t[i]) begin
        errs++;
        $display("FAIL vecw_%0d: p=%h want %h", i, p, e_t[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone;
    logic [11:0] pcap;
    ndone = 0;
    pcap = '0;
    @(negedge clk);
    s_sm = 1'b0; s_a = 8'd3; s_b = 4'd5; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0; s_a = 8'd7; s_b = 4'd7;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (s_done) begin
        ndone++;
        pcap = s_p;
      end
      if (e == 4) begin
        checks += 2;
        if (s_done !== 1'b1) begin
          errs++;
          $display("FAIL busy_done_edge: done=%b at edge 4 want 1", s_done);
        end
        if (s_busy !== 1'b1) begin
          errs++;
          $display("FAIL busy_in_done: busy=%b want 1", s_busy);
        end
      end
      if (e == 5) begin
        checks++;
        if (s_busy !== 1'b0) begin
          errs++;
          $display("FAIL busy_after: busy=%b want 0", s_busy);
        end
      end
      s_start = (e == 1 || e == 3);
    end
    s_start = 1'b0;
    checks += 2;
    if (ndone !== 1) begin
      errs++;
      $display("FAIL busy_ndone: dones=%0d want 1", ndone);
    end
    if (pcap !== 12'd15) begin
      errs++;
      $display("FAIL busy_p: p=%h want 00f", pcap);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    logic [11:0] p;
    ndone = 0;
    @(negedge clk);
    s_sm = 1'b0; s_a = 8'd9; s_b = 4'd3; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks += 2;
    if ({s_busy, s_done} !== 2'b00) begin
      errs++;
      $display("FAIL rstmid_ctl: busy,done=%b want 00", {s_busy, s_done});
    end
    if (s_p !== 12'h000) begin
      errs++;
      $display("FAIL rstmid_p: p=%h want 000", s_p);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (s_done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errs++;
      $display("FAIL rstmid_nodone: dones=%0d want 0", ndone);
    end
    run8(1'b1, 8'hF9, 4'h3, p, lat);
    checks += 2;
    if (lat !== 4) begin
      errs++;
      $display("FAIL rstmid_lat: latency=%0d want 4", lat);
    end
    if (p !== 12'hFEB) begin
      errs++;
      $display("FAIL rstmid_after: p=%h want feb", p);
    end
  endtask

  task automatic test_random();
    logic [11:0]  p8;
    logic [319:0] pw;
    logic [255:0] ra;
    logic [63:0]  rb;
    logic         sm;
    logic [7:0]   a8;
    logic [3:0]   b4;
    int lat;
    for (int i = 0; i < 200; i++) begin
      sm = 1'($urandom);
      a8 = 8'($urandom);
      b4 = 4'($urandom);
      run8(sm, a8, b4, p8, lat);
      checks += 2;
      if (lat !== 4) begin
        errs++;
        $display("FAIL rnd8_lat_%0d: latency=%0d want 4", i, lat);
      end
      if (p8 !== ref8(sm, a8, b4)) begin
        errs++;
        $display("FAIL rnd8_%0d: sm=%b a=%h b=%h p=%h want %h",
                 i, sm, a8, b4, p8, ref8(sm, a8, b4));
      end
    end
    for (int i = 0; i < 20; i++) begin
      sm = 1'($urandom);
      for (int j = 0; j < 8; j++) ra[j*32 +: 32] = $urandom;
      rb = {$urandom, $urandom};
      run_wide(sm, ra, rb, pw, lat);
      checks += 2;
      if (lat !== 34) begin
        errs++;
        $display("FAIL rndw_lat_%0d: latency=%0d want 34", i, lat);
      end
      if (pw !== ref_wide(sm, ra, rb)) begin
        errs++;
        $display("FAIL rndw_%0d: p=%h want %h",
                 i, pw, ref_wide(sm, ra, rb));
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_small_vectors();
    test_wide_vectors();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
